// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory responder with byte-enabled RAM and an MMIO page (GPIO, timer, compare, status)
//   clk, reset      : clock, synchronous active-high reset
//   access_address  : byte address (word index = [7:2])
//   data_write      : write data, little-endian byte lanes
//   byte_enable     : per-lane write enables
//   write_enable    : 1 = write cycle, 0 = read cycle
//   data_read       : registered read data, one cycle latency
//   gpio_out        : GPIO output register
//   timer_irq       : level copy of the sticky match flag
//   Optional macro DATA_MEM_RDW_NEW_EN: write cycles return the merged post-write word instead of the old word.
module data_mem_responder #(
  parameter int RAM_WORDS = 60,
  parameter logic [7:0] MMIO_BASE = 8'hF0,
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  access_address,
  input  logic [31:0] data_write,
  input  logic [3:0]  byte_enable,
  input  logic        write_enable,
  output logic [31:0] data_read,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);
  localparam int AW = RAM_WORDS > 1 ? $clog2(RAM_WORDS) : 1;
  localparam logic [8:0] RAM_END = 9'(4 * RAM_WORDS);
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] cmp, wmask, ram_q, ram_new, cmp_new, rd_old, rd_d;
  logic [TIMER_W-1:0] cnt, cnt_nxt;
  logic [7:0] wa;
  logic [AW-1:0] idx;
  logic flag, flag_nxt, match, clr, in_ram, is_gpio, is_cnt, is_cmp, is_stat, cnt_clr;
  assign wa = {access_address[7:2], 2'b00};
  assign idx = access_address[AW+1:2];
  assign in_ram = {1'b0, access_address} < RAM_END;
  assign is_gpio = wa == MMIO_BASE;
  assign is_cnt = wa == MMIO_BASE + 8'd4;
  assign is_cmp = wa == MMIO_BASE + 8'd8;
  assign is_stat = wa == MMIO_BASE + 8'd12;
  assign wmask = {{8{byte_enable[3]}}, {8{byte_enable[2]}}, {8{byte_enable[1]}}, {8{byte_enable[0]}}};
  assign ram_q = in_ram ? mem[idx] : '0;
  assign ram_new = (ram_q & ~wmask) | (data_write & wmask);
  assign cmp_new = (cmp & ~wmask) | (data_write & wmask);
  assign cnt_clr = write_enable && is_cnt && |byte_enable;
  assign cnt_nxt = cnt_clr ? '0 : cnt + 1'b1;
  // Match looks at the value the counter will hold after this edge.
  assign match = cmp != '0 && 32'(cnt_nxt) == cmp;
  assign clr = write_enable && is_stat && byte_enable[0] && data_write[0];
  assign flag_nxt = match | (flag & ~clr);
  assign timer_irq = flag;
  assign rd_old = in_ram ? ram_q : is_gpio ? {24'b0, gpio_out} : is_cnt ? 32'(cnt) :
                  is_cmp ? cmp : is_stat ? {31'b0, flag} : '0;
`ifdef DATA_MEM_RDW_NEW_EN
  logic [31:0] rd_new;
  assign rd_new = in_ram ? ram_new : is_gpio ? {24'b0, byte_enable[0] ? data_write[7:0] : gpio_out} :
                  is_cnt ? (cnt_clr ? '0 : 32'(cnt)) : is_cmp ? cmp_new :
                  is_stat ? {31'b0, byte_enable[0] ? flag_nxt : flag} : '0;
  assign rd_d = write_enable ? rd_new : rd_old;
`else
  assign rd_d = rd_old;
`endif
  // RAM has no reset so writes presented during reset still land.
  always_ff @(posedge clk)
    if (write_enable && in_ram && |byte_enable) mem[idx] <= ram_new;
  always_ff @(posedge clk) begin
    if (reset) begin
      data_read <= '0;
      gpio_out <= '0;
      cnt <= '0;
      cmp <= '0;
      flag <= 1'b0;
    end else begin
      data_read <= rd_d;
      cnt <= cnt_nxt;
      flag <= flag_nxt;
      if (write_enable && is_gpio && byte_enable[0]) gpio_out <= data_write[7:0];
      if (write_enable && is_cmp) cmp <= cmp_new;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b1, write_enable = 1'b0;
  logic [7:0] access_address = '0;
  logic [31:0] data_write = '0;
  logic [3:0] byte_enable = '0;
  logic [31:0] data_read;
  logic [7:0] gpio_out;
  logic timer_irq, any_irq;
  logic [31:0] rdw_exp;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.RAM_WORDS(59), .MMIO_BASE(8'hF0), .TIMER_W(8)) dut (
    .clk(clk), .reset(reset), .access_address(access_address), .data_write(data_write),
    .byte_enable(byte_enable), .write_enable(write_enable), .data_read(data_read),
    .gpio_out(gpio_out), .timer_irq(timer_irq));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b, input logic w);
    access_address = a;
    data_write = d;
    byte_enable = b;
    write_enable = w;
    @(negedge clk);
  endtask
  task automatic rd(input logic [7:0] a);
    step(a, 32'h0, 4'h0, 1'b0);
  endtask
  initial begin
    rd(8'h00);
    rd(8'h00);
    check("rst_rd", data_read, 32'h0);
    check("rst_gpio", {24'b0, gpio_out}, 32'h0);
    check("rst_irq", {31'b0, timer_irq}, 32'h0);
    reset = 1'b0;
    step(8'hF8, 32'h5, 4'hF, 1'b1);
    step(8'hF4, 32'h0, 4'h1, 1'b1);
    rd(8'hF4);
    check("cnt_after_clr", data_read, 32'h0);
    rd(8'h00);
    rd(8'h00);
    rd(8'h00);
    check("irq_before_match", {31'b0, timer_irq}, 32'h0);
    rd(8'h00);
    check("irq_match", {31'b0, timer_irq}, 32'h1);
    rd(8'hFC);
    check("status_rd", data_read, 32'h1);
    rd(8'hF8);
    check("cmp_rd", data_read, 32'h5);
    step(8'hFC, 32'h1, 4'h1, 1'b1);
    check("status_clr", {31'b0, timer_irq}, 32'h0);
    any_irq = 1'b0;
    for (int i = 0; i < 252; i++) begin
      rd(8'h00);
      any_irq |= timer_irq;
    end
    check("no_irq_before_wrap", {31'b0, any_irq}, 32'h0);
    rd(8'h00);
    check("irq_after_wrap", {31'b0, timer_irq}, 32'h1);
    step(8'hFC, 32'h1, 4'h1, 1'b1);
    check("status_clr2", {31'b0, timer_irq}, 32'h0);
    step(8'hF4, 32'hFFFF_FFFF, 4'h8, 1'b1);
    for (int i = 0; i < 4; i++) rd(8'h00);
    check("irq_pre_race", {31'b0, timer_irq}, 32'h0);
    step(8'hFC, 32'h1, 4'h1, 1'b1);
    check("set_wins", {31'b0, timer_irq}, 32'h1);
    rd(8'hF4);
    check("cnt_at_match", data_read, 32'h5);
    step(8'h04, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd(8'h04);
    check("ram_rd04", data_read, 32'hDEAD_BEEF);
    rd(8'h06);
    check("ram_rd06", data_read, 32'hDEAD_BEEF);
    step(8'h08, 32'hAABB_CCDD, 4'hF, 1'b1);
    step(8'h08, 32'h1122_3344, 4'h5, 1'b1);
    rd(8'h08);
    check("ram_lanes", data_read, 32'hAA22_CC44);
    step(8'h08, 32'hFFFF_FFFF, 4'h0, 1'b1);
    rd(8'h08);
    check("ram_be0", data_read, 32'hAA22_CC44);
    step(8'hF0, 32'h0000_00A5, 4'h1, 1'b1);
    check("gpio_out", {24'b0, gpio_out}, 32'hA5);
    rd(8'hF0);
    check("gpio_rd", data_read, 32'hA5);
    step(8'hF0, 32'hFFFF_FF5A, 4'hE, 1'b1);
    rd(8'hF2);
    check("gpio_upper", data_read, 32'hA5);
    step(8'h10, 32'h1, 4'hF, 1'b1);
    step(8'h10, 32'h2, 4'hF, 1'b1);
`ifdef DATA_MEM_RDW_NEW_EN
    rdw_exp = 32'h2;
`else
    rdw_exp = 32'h1;
`endif
    check("rdw", data_read, rdw_exp);
    rd(8'h10);
    check("rdw_after", data_read, 32'h2);
    step(8'hE8, 32'h1234_5678, 4'hF, 1'b1);
    rd(8'hE8);
    check("ram_last", data_read, 32'h1234_5678);
    step(8'hEC, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd(8'hEC);
    check("unmapped_ec", data_read, 32'h0);
    rd(8'h04);
    reset = 1'b1;
    step(8'h20, 32'h77, 4'hF, 1'b1);
    check("rst_abandon", data_read, 32'h0);
    check("rst_gpio2", {24'b0, gpio_out}, 32'h0);
    check("rst_irq2", {31'b0, timer_irq}, 32'h0);
    reset = 1'b0;
    rd(8'h20);
    check("rst_ram_wr", data_read, 32'h77);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor data-access interface: serves `access_address`, `data_write`, `byte_enable` and `write_enable`, and returns `data_read`.
- Replaces the plain data-memory instance in the top level.
- Contains a byte-enabled word RAM in the low address space and a small memory-mapped I/O page at the top: GPIO output, free-running timer, timer compare, sticky status flag.
- Read latency is one cycle, matching the synchronous memory the processor already expects.

Parameters:
- RAM_WORDS, 60, number of 32-bit RAM words; RAM occupies byte addresses 0x00 to 4*RAM_WORDS-1.
- MMIO_BASE, 8'hF0, byte address of the first MMIO register; must be word aligned and at or above 4*RAM_WORDS.
- TIMER_W, 32, timer counter width in bits (at most 32; read data is zero-extended).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- access_address  input  8  byte address; word index = access_address[7:2]; bits [1:0] ignored.
- data_write  input  32  write data, little-endian byte lanes.
- byte_enable  input  4  lane enables; bit i qualifies data_write[8i+7:8i].
- write_enable  input  1  1 = write cycle, 0 = read cycle.
- data_read  output  32  registered read data for the address presented on the previous edge.
- gpio_out  output  8  GPIO output register.
- timer_irq  output  1  level copy of the status match flag.

Behaviour:
- Reset (sync, active-high):
  - data_read=0, gpio_out=0, timer count=0, compare=0, match flag=0, timer_irq=0.
  - RAM contents are not reset.
- Address decode, per word address:
  - RAM when address < 4*RAM_WORDS.
  - GPIO at MMIO_BASE+0, COUNT at +4, CMP at +8, STATUS at +C.
  - All other addresses are unmapped: reads return 0, writes are dropped.
- Read:
  - Every cycle, data_read <= contents of the word at access_address, sampled at edge N and visible after edge N.
  - A read with write_enable=1 returns the pre-write contents; see the Optional Feature.
- Write:
  - Occurs when write_enable=1; each lane with byte_enable[i]=1 is updated.
  - byte_enable=0000 with write_enable=1 is a no-op.
- GPIO:
  - Lane 0 is writable; lanes 1-3 are ignored on write and read as 0.
- COUNT:
  - Increments by 1 every cycle and wraps from 2^TIMER_W-1 to 0.
  - A write with any enabled lane clears it to 0 regardless of data. This overrides that cycle's increment, so the next value is 0.
- CMP:
  - Fully byte-writable per lane.
- Match:
  - When compare != 0 and the next count value equals compare, the match flag sets on that edge.
  - compare=0 disables matching.
- STATUS:
  - bit0 = match flag; other bits read 0.
  - Writing 1 to bit0 with lane 0 enabled clears the flag.
  - If a clear and a match occur on the same edge, set wins.
- timer_irq equals the flag register directly, with no extra delay.
- COUNT read returns the value held before the edge on which it is sampled.
- Reset asserted mid-operation:
  - Abandons any in-flight read: data_read=0 on the following cycle.
  - RAM writes presented in the reset cycle are still performed; MMIO writes in that cycle are discarded.

Optional Feature:
- Macro: DATA_MEM_RDW_NEW_EN.
- Defined: a write cycle returns the merged post-write word on data_read next cycle (new-data read-during-write) for both RAM and MMIO. Disabled lanes show old data.
- Undefined: a write cycle returns the pre-write word (old data), equivalent to the default synchronous memory behaviour.

Test Plan:
- Reset, then write 0xDEADBEEF with be=1111 to address 0x04, then read 0x04 -> data_read=0xDEADBEEF one cycle after the read edge; read 0x06 also returns 0xDEADBEEF.
- Write 0x11223344 with be=0101 over a word holding 0xAABBCCDD -> read returns 0xAA22CC44; be=0000 write leaves it unchanged.
- Write 0x000000A5 with be=0001 to MMIO_BASE -> gpio_out=0xA5 after the edge; read GPIO -> 0x000000A5.
- Write CMP=5 and write COUNT (clear) on the same cycle as reset release -> flag and timer_irq assert on the edge where count becomes 5. Write STATUS=1 -> flag clears. With CMP=5 and count wrapping, the flag sets again at the next match.
- Simultaneous clear and match: time the STATUS write to coincide with count reaching CMP -> flag stays 1.
- Read-during-write to RAM 0x10 (old 0x1, write 0x2) -> data_read=0x1 without the macro, 0x2 with DATA_MEM_RDW_NEW_EN; a read of unmapped address 0xEC with RAM_WORDS=59 returns 0.
